// File: rtl/ws2812b_decoder.sv
// WS2812B single-wire receiver: measures high-pulse widths, assembles 24-bit
// MSB-first words and hands them out over valid/ready with frame/error status.
module ws2812b_decoder #(
    parameter int CLK_HZ       = 20000000,
    parameter int BIT_THRESH   = 12,
    parameter int MIN_HIGH     = 3,
    parameter int MAX_HIGH     = 30,
    parameter int LATCH_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        ready,
    output logic [23:0] data,
    output logic        valid,
    output logic        latch,
    output logic [8:0]  pixel_count,
    output logic        error,
    output logic        overrun
);
    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(LATCH_CYCLES + 1) + ((CLK_HZ > 0) ? 0 : 1);

    localparam logic [HW-1:0] HI_SAT  = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0] HI_MIN  = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HI_MAX  = HW'(MAX_HIGH);
    localparam logic [HW-1:0] HI_ONE  = HW'(BIT_THRESH);
    localparam logic [LW-1:0] LO_LAT  = LW'(LATCH_CYCLES);
    // The fall is seen two cycles late, so low time starts pre-counted.
    localparam logic [LW-1:0] LO_INIT = LW'(2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_DISC = 2'd3;

    logic [1:0]    rst_sync_q;
    logic          rst_int_n;
    logic          s1_q, s2_q, lvl_q, rise_q, fall_q;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] high_cnt_q, high_cnt_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [23:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic [8:0]    pix_q, pix_d;
    logic          latch_q, latch_d;
    logic          error_q, error_d;
    logic          overrun_q, overrun_d;
    logic          word_done;
    logic [23:0]   new_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Registered edge pulses keep the FSM input timing aligned with lvl_q.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            lvl_q  <= s2_q;
            rise_q <= s2_q & ~lvl_q;
            fall_q <= ~s2_q & lvl_q;
        end
    end

    assign new_word = {shift_q[22:0], (high_cnt_q >= HI_ONE)};

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        pix_d      = pix_q;
        latch_d    = 1'b0;
        error_d    = 1'b0;
        overrun_d  = 1'b0;
        word_done  = 1'b0;

        if (valid_q && ready) valid_d = 1'b0;
        if (latch_q) pix_d = 9'd0;

        case (state_q)
            S_IDLE: begin
                if (rise_q) begin
                    high_cnt_d = HW'(1);
                    state_d    = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall_q) begin
                    low_cnt_d = LO_INIT;
                    if (high_cnt_q < HI_MIN || high_cnt_q > HI_MAX) begin
                        error_d = 1'b1;
                        state_d = S_DISC;
                    end else begin
                        shift_d = new_word;
                        state_d = S_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            word_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (high_cnt_q != HI_SAT) begin
                    high_cnt_d = high_cnt_q + HW'(1);
                end
            end
            S_LOW: begin
                if (rise_q) begin
                    low_cnt_d  = '0;
                    high_cnt_d = HW'(1);
                    state_d    = S_HIGH;
                end else if (low_cnt_q == LO_LAT) begin
                    latch_d   = 1'b1;
                    state_d   = S_IDLE;
                    bit_cnt_d = 5'd0;
                    if (bit_cnt_q != 5'd0) error_d = 1'b1;
                end else begin
                    low_cnt_d = low_cnt_q + LW'(1);
                end
            end
            default: begin
                if (low_cnt_q == LO_LAT) begin
                    latch_d   = 1'b1;
                    bit_cnt_d = 5'd0;
                    state_d   = S_IDLE;
                end else if (lvl_q) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_cnt_q + LW'(1);
                end
            end
        endcase

        if (word_done) begin
            if (pix_q != 9'd511) pix_d = pix_q + 9'd1;
            if (!valid_q || ready) begin
                data_d  = new_word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= S_IDLE;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            bit_cnt_q  <= 5'd0;
            shift_q    <= 24'd0;
            data_q     <= 24'd0;
            valid_q    <= 1'b0;
            pix_q      <= 9'd0;
            latch_q    <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pix_q      <= pix_d;
            latch_q    <= latch_d;
            error_q    <= error_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign latch       = latch_q;
    assign pixel_count = pix_q;
    assign error       = error_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_ws2812b_decoder.sv
// Directed bench for ws2812b_decoder: line waveforms are generated here and
// expected words go through a scoreboard queue checked at each handshake.
module tb_ws2812b_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        ready = 1'b0;
    logic [23:0] data;
    logic        valid, latch, error, overrun;
    logic [8:0]  pixel_count;

    ws2812b_decoder dut (
        .clk(clk), .rst_n(rst_n), .din(din), .ready(ready),
        .data(data), .valid(valid), .latch(latch),
        .pixel_count(pixel_count), .error(error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    logic [23:0] sb[$];
    int          latch_cnt = 0, err_cnt = 0, ovr_cnt = 0, words_rx = 0, err_latch = 0;
    logic [8:0]  pc_at_latch = '0;
    logic [31:0] exp_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (latch) begin
                latch_cnt++;
                pc_at_latch = pixel_count;
                if (error) err_latch++;
            end
            if (error)   err_cnt++;
            if (overrun) ovr_cnt++;
            if (valid && ready) begin
                exp_w = (sb.size() != 0) ? {8'h0, sb.pop_front()} : 32'hDEADBEEF;
                check("word", {8'h0, data}, exp_w);
                words_rx++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int h, input int p);
        din = 1'b1; cyc(h);
        din = 1'b0; cyc(p - h);
    endtask

    task automatic send_word(input logic [23:0] w, input int t0, input int t1, input int p);
        for (int i = 23; i >= 0; i--) send_bit(w[i] ? t1 : t0, p);
    endtask

    task automatic gap(input int n);
        din = 1'b0; cyc(n);
    endtask

    int l0, e0, o0, w0;
    logic [23:0] rw;

    initial begin
        // Reset and idle line
        rst_n = 1'b0; cyc(3);
        rst_n = 1'b1; cyc(3);
        check("rst_data", {8'h0, data}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_latch", {31'h0, latch}, 32'h0);
        check("rst_pixcnt", {23'h0, pixel_count}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        gap(5000);
        check("idle_no_latch", latch_cnt, 0);
        check("idle_no_error", err_cnt, 0);
        check("idle_no_valid", {31'h0, valid}, 32'h0);

        // Single word with ready high
        ready = 1'b1;
        l0 = latch_cnt;
        sb.push_back(24'hA5C3F0);
        send_word(24'hA5C3F0, 8, 16, 25);
        cyc(5);
        check("w1_received", words_rx, 1);
        check("w1_valid_dropped", {31'h0, valid}, 32'h0);
        gap(1100);
        check("w1_latch_once", latch_cnt - l0, 1);
        check("w1_pc_at_latch", {23'h0, pc_at_latch}, 32'd1);
        check("w1_pc_cleared", {23'h0, pixel_count}, 32'd0);
        check("w1_no_error", err_cnt, 0);

        // Backpressure and overrun
        ready = 1'b0;
        send_word(24'h000001, 8, 16, 25);
        send_word(24'hFFFFFF, 8, 16, 25);
        cyc(10);
        check("bp_data_held", {8'h0, data}, 32'h000001);
        check("bp_valid", {31'h0, valid}, 32'h1);
        check("bp_overrun", ovr_cnt, 1);
        check("bp_pixcnt", {23'h0, pixel_count}, 32'd2);
        sb.push_back(24'h000001);
        ready = 1'b1;
        cyc(2);
        check("bp_valid_drop", {31'h0, valid}, 32'h0);
        check("bp_words", words_rx, 2);
        check("bp_sb_empty", sb.size(), 0);
        gap(1100);

        // Partial word at frame end
        e0 = err_cnt; l0 = latch_cnt;
        for (int i = 0; i < 10; i++) send_bit((i % 2) ? 16 : 8, 25);
        gap(1100);
        check("part_error", err_cnt - e0, 1);
        check("part_latch", latch_cnt - l0, 1);
        check("part_same_cycle", err_latch, 1);
        check("part_pc", {23'h0, pc_at_latch}, 32'd0);
        check("part_no_word", words_rx, 2);

        // Short glitch, then bits that must be discarded
        e0 = err_cnt; l0 = latch_cnt;
        din = 1'b1; cyc(2); din = 1'b0; cyc(20);
        send_word(24'h123456, 8, 16, 25);
        gap(1100);
        check("glitch_error", err_cnt - e0, 1);
        check("glitch_latch", latch_cnt - l0, 1);
        check("glitch_no_word", words_rx, 2);
        check("glitch_pc", {23'h0, pixel_count}, 32'd0);

        // Over-long pulse, then bits that must be discarded
        e0 = err_cnt; l0 = latch_cnt;
        din = 1'b1; cyc(31); din = 1'b0; cyc(20);
        send_word(24'h654321, 8, 16, 25);
        gap(1100);
        check("long_error", err_cnt - e0, 1);
        check("long_latch", latch_cnt - l0, 1);
        check("long_no_word", words_rx, 2);
        check("long_no_extra_errlatch", err_latch, 1);

        // Width limits: 30-cycle ones and 3-cycle zeros are legal
        e0 = err_cnt;
        sb.push_back(24'h800001);
        send_word(24'h800001, 3, 30, 40);
        gap(1100);
        check("edge_words", words_rx, 3);
        check("edge_no_error", err_cnt - e0, 0);
        check("edge_pc", {23'h0, pc_at_latch}, 32'd1);

        // Encoder-style loopback of 140 random words
        e0 = err_cnt; l0 = latch_cnt; o0 = ovr_cnt; w0 = words_rx;
        for (int i = 0; i < 140; i++) begin
            rw = 24'($urandom);
            sb.push_back(rw);
            send_word(rw, 8, 16, 20);
        end
        gap(1100);
        check("lb_words", words_rx - w0, 140);
        check("lb_sb_empty", sb.size(), 0);
        check("lb_latch", latch_cnt - l0, 1);
        check("lb_pc", {23'h0, pc_at_latch}, 32'd140);
        check("lb_no_error", err_cnt - e0, 0);
        check("lb_no_overrun", ovr_cnt - o0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
